// File: rtl/demux_param_reg.sv
// demux_param_reg
//   Registered, parameterized demultiplexer. One DW-bit input stream is
//   steered by in_sel to one of N output channels. Each channel owns a
//   one-entry holding register with its own valid/ready handshake.
//
// Parameters
//   DW   : data width of one word
//   N    : number of output channels (N >= 2)
//   SELW : select width, derived from N (leave at default)
//
// Ports
//   clk        : system clock, everything on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : input word valid
//   in_data    : input word
//   in_sel     : destination channel index
//   in_bcast   : (DEMUX_BCAST_EN builds only) deliver word to every channel
//   in_ready   : block accepts the input word this cycle
//   out_valid  : per-channel holding register full (this is also the
//                per-channel FSM state: 1 = FULL, 0 = EMPTY)
//   out_data   : packed channel data, channel k at [k*DW +: DW]
//   out_ready  : per-channel consumer ready
//   sel_err    : one-cycle pulse after an out-of-range select word is dropped
//   drop_cnt   : saturating count of dropped words
//
// Optional feature macro: DEMUX_BCAST_EN (adds in_bcast broadcast input).
//
// Handshake: a word moves across an interface on every rising edge where
//   valid and ready are both 1. Ready never depends on valid on the same
//   interface, and out_valid comes straight from flops, so no combinational
//   path exists from out_ready back to out_valid.

module demux_param_reg #(
  parameter int DW   = 8,
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  input  logic [SELW-1:0]   in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic              in_bcast,
`endif
  output logic              in_ready,
  output logic [N-1:0]      out_valid,
  output logic [N*DW-1:0]   out_data,
  input  logic [N-1:0]      out_ready,
  output logic              sel_err,
  output logic [7:0]        drop_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t   state [N];

  logic [N-1:0] hit;        // one-hot decode of in_sel (all zero if out of range)
  logic [N-1:0] slot_free;  // channel can take a word at the next edge
  logic [N-1:0] load;       // channel register captures in_data at the next edge
  logic         sel_ok;
  logic         bcast;
  logic         accept;
  logic         drop;

`ifdef DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  always_comb begin
    for (int k = 0; k < N; k++) begin
      out_valid[k] = (state[k] == FULL);
    end
  end

  always_comb begin
    hit = '0;
    for (int k = 0; k < N; k++) begin
      hit[k] = (32'(in_sel) == 32'(k));
    end
    // An out-of-range select decodes to no channel at all; this only
    // happens when N is not a power of two.
    sel_ok    = |hit;
    // A full register is still free if its consumer drains it this cycle,
    // which lets a channel stream one word per clock.
    slot_free = ~out_valid | out_ready;

    if (bcast) begin
      in_ready = &slot_free;
    end else if (!sel_ok) begin
      in_ready = 1'b1;
    end else begin
      in_ready = |(hit & slot_free);
    end

    accept = in_valid & in_ready;
    drop   = accept & ~bcast & ~sel_ok;

    load = '0;
    if (accept) begin
      load = bcast ? '1 : hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        state[k] <= EMPTY;
      end
      out_data <= '0;
      sel_err  <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      for (int k = 0; k < N; k++) begin
        case (state[k])
          EMPTY: if (load[k]) state[k] <= FULL;
          // Drain with a simultaneous load keeps the channel FULL.
          FULL:  if (out_ready[k] && !load[k]) state[k] <= EMPTY;
        endcase
        // Data is not cleared on drain; it keeps its last value.
        if (load[k]) begin
          out_data[k*DW +: DW] <= in_data;
        end
      end
      sel_err <= drop;
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_param_reg.sv
// tb_demux_param_reg
//   Directed bench for demux_param_reg. Two instances: dut4 (N=4) carries
//   the main traffic, dut3 (N=3) exercises out-of-range selects. A
//   word-level model of the channels runs alongside and a negedge compare
//   process checks every output of both instances each cycle; a queue
//   scoreboard checks channel-1 delivery order; literal checks pin the
//   headline scenarios.

module tb_demux_param_reg;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut4 signals
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'h00;
  logic [1:0]  in_sel   = 2'd0;
  logic [3:0]  out_ready = 4'h0;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic        sel_err;
  logic [7:0]  drop_cnt;
  logic        bcast_sig;
`ifdef DEMUX_BCAST_EN
  logic        in_bcast = 1'b0;
  assign bcast_sig = in_bcast;
`else
  assign bcast_sig = 1'b0;
`endif

  // dut3 signals
  logic        in_valid3 = 1'b0;
  logic [7:0]  in_data3  = 8'h00;
  logic [1:0]  in_sel3   = 2'd0;
  logic [2:0]  out_ready3 = 3'h0;
  logic        in_ready3;
  logic [2:0]  out_valid3;
  logic [23:0] out_data3;
  logic        sel_err3;
  logic [7:0]  drop_cnt3;

  demux_param_reg #(.DW(8), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_sel(in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast(in_bcast),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .sel_err(sel_err), .drop_cnt(drop_cnt)
  );

  demux_param_reg #(.DW(8), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_data(in_data3),
    .in_sel(in_sel3),
`ifdef DEMUX_BCAST_EN
    .in_bcast(1'b0),
`endif
    .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
    .out_ready(out_ready3), .sel_err(sel_err3), .drop_cnt(drop_cnt3)
  );

  // ---------------- checking bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is a one-word mailbox: empty or holding a word.
  int          nch [2] = '{4, 3};
  logic        mv [2][4];
  logic [7:0]  md [2][4];
  logic        merr [2];
  int          mdrop [2];
  logic [7:0]  exp_q[$];   // words expected out of dut4 channel 1, in order

  task automatic get_in(input int i, output logic v, output logic [7:0] d,
                        output int s, output logic b, output logic [3:0] r);
    if (i == 0) begin
      v = in_valid; d = in_data; s = int'(in_sel); b = bcast_sig; r = out_ready;
    end else begin
      v = in_valid3; d = in_data3; s = int'(in_sel3); b = 1'b0; r = {1'b0, out_ready3};
    end
  endtask

  function automatic logic m_ready(input int i, input int s, input logic b, input logic [3:0] r);
    if (b) begin
      for (int k = 0; k < nch[i]; k++) if (mv[i][k] && !r[k]) return 1'b0;
      return 1'b1;
    end
    if (s >= nch[i]) return 1'b1;
    return !mv[i][s] || r[s];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 4; k++) begin mv[i][k] = 1'b0; md[i][k] = 8'h00; end
        merr[i] = 1'b0; mdrop[i] = 0;
      end
      exp_q.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic v, b, acc;
        logic [7:0] d;
        logic [3:0] r;
        int s;
        get_in(i, v, d, s, b, r);
        acc = v && m_ready(i, s, b, r);
        merr[i] = 1'b0;
        for (int k = 0; k < nch[i]; k++) begin
          if (acc && (b || s == k)) begin
            mv[i][k] = 1'b1; md[i][k] = d;
            if (i == 0 && k == 1) exp_q.push_back(d);
          end else if (mv[i][k] && r[k]) begin
            mv[i][k] = 1'b0;
          end
        end
        if (acc && !b && s >= nch[i]) begin
          merr[i] = 1'b1;
          if (mdrop[i] < 255) mdrop[i]++;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        logic v, b;
        logic [7:0] d;
        logic [3:0] r, ev;
        logic [31:0] ed;
        int s;
        get_in(i, v, d, s, b, r);
        ev = '0; ed = '0;
        for (int k = 0; k < nch[i]; k++) begin ev[k] = mv[i][k]; ed[k*8 +: 8] = md[i][k]; end
        if (i == 0) begin
          chk("in_ready4",  in_ready,  m_ready(0, s, b, r));
          chk("out_valid4", out_valid, ev);
          chk("out_data4",  out_data,  ed);
          chk("sel_err4",   sel_err,   merr[0]);
          chk("drop_cnt4",  drop_cnt,  mdrop[0]);
        end else begin
          chk("in_ready3",  in_ready3,  m_ready(1, s, b, r));
          chk("out_valid3", out_valid3, ev);
          chk("out_data3",  out_data3,  ed);
          chk("sel_err3",   sel_err3,   merr[1]);
          chk("drop_cnt3",  drop_cnt3,  mdrop[1]);
        end
      end
      // Scoreboard: a channel-1 handshake is about to happen at the next edge.
      if (out_valid[1] && out_ready[1]) begin
        if (exp_q.size() == 0) chk("sb_ch1_underflow", 64'd1, 64'd0);
        else chk("sb_ch1_order", out_data[15:8], exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a word to dut4 and hold it until accepted; returns at edge+1
  // with in_valid still high so calls can stream back to back.
  task automatic send(input logic [7:0] d, input logic [1:0] s);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_sel = s;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    chk("send_accept", in_ready, 1'b1);
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset then idle.
    @(negedge clk);
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_out_data",  out_data,  32'h0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_drop_cnt",  drop_cnt,  8'd0);
    step();

    // Single word to channel 2, consumer stalled.
    out_ready = 4'h0;
    send(8'hA5, 2'd2);
    idle();
    @(negedge clk);
    chk("a5_out_valid", out_valid, 4'b0100);
    chk("a5_lane2",     out_data[23:16], 8'hA5);
    step();
    in_valid = 1'b1; in_data = 8'h3C; in_sel = 2'd2;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("3c_stalled", in_ready, 1'b0);
      step();
    end
    out_ready = 4'b0100;
    @(negedge clk);
    chk("3c_passthru_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; out_ready = 4'h0;
    @(negedge clk);
    chk("3c_out_valid", out_valid, 4'b0100);
    chk("3c_lane2",     out_data[23:16], 8'h3C);
    step();
    out_ready = 4'b0100;
    step();
    out_ready = 4'h0;
    step();

    // Back-to-back streaming to channel 1.
    out_ready = 4'b0010;
    t0 = cyc;
    for (int w = 1; w <= 16; w++) send(8'(w), 2'd1);
    idle();
    chk("stream_cycles", 64'(cyc - t0), 64'd16);
    step();
    step();
    out_ready = 4'h0;
    step();

    // Interleave all channels with consumers stalled.
    for (int k = 0; k < 4; k++) send(8'h10 + 8'(k), 2'(k));
    idle();
    @(negedge clk);
    chk("fill_out_valid", out_valid, 4'b1111);
    chk("fill_out_data",  out_data,  32'h13121110);
    step();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'hEE; in_sel = 2'(k);
      @(negedge clk);
      chk("fill_stalled", in_ready, 1'b0);
      step();
    end
    idle();
    out_ready = 4'hF;
    step();
    out_ready = 4'h0;
    step();

    // Out-of-range select on the N=3 instance.
    in_valid3 = 1'b1; in_sel3 = 2'd0; in_data3 = 8'h77;
    step();
    in_sel3 = 2'd3; in_data3 = 8'hFF;
    @(negedge clk);
    chk("oor_in_ready", in_ready3, 1'b1);
    step();
    in_valid3 = 1'b0;
    @(negedge clk);
    chk("oor_sel_err",   sel_err3,   1'b1);
    chk("oor_out_valid", out_valid3, 3'b001);
    chk("oor_drop_cnt",  drop_cnt3,  8'd1);
    step();
    @(negedge clk);
    chk("oor_sel_err_clear", sel_err3, 1'b0);
    step();
    in_valid3 = 1'b1;
    repeat (299) step();
    in_valid3 = 1'b0;
    @(negedge clk);
    chk("oor_drop_sat", drop_cnt3, 8'd255);
    step();

    // Asynchronous reset with channels 1 and 3 holding words.
    send(8'h21, 2'd1);
    send(8'h23, 2'd3);
    idle();
    @(negedge clk);
    chk("pre_rst_out_valid", out_valid, 4'b1010);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 4'b0000);
    chk("async_rst_out_data",  out_data,  32'h0);
    chk("async_rst_drop3",     drop_cnt3, 8'd0);
    step();
    rst_n = 1'b1;
    step();

`ifdef DEMUX_BCAST_EN
    in_bcast = 1'b1;
    send(8'h5A, 2'd0);
    idle();
    in_bcast = 1'b0;
    @(negedge clk);
    chk("bcast_out_valid", out_valid, 4'b1111);
    chk("bcast_out_data",  out_data,  32'h5A5A5A5A);
    step();
`endif

    // Drain everything and close out the scoreboard.
    out_ready = 4'hF; out_ready3 = 3'h7;
    repeat (3) step();
    @(negedge clk);
    chk("final_out_valid", out_valid, 4'b0000);
    chk("final_sb_empty",  64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
